// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin shared-register writer with burst-capped grants
module reg_write_arbiter #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MAXB = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           upd,
    output logic           busy
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAXB + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAXB);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d, cand, hot;
    logic [W-1:0]    q_q, q_d;
    logic            upd_q, upd_d;
    logic [PW-1:0]   ptr_q, ptr_d, own, nxt, start, win;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            own_req, others, wr, rot;
    int              jj;

    // state register: every piece of state clears asynchronously on clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            q_q     <= '0;
            upd_q   <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            upd_q   <= upd_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // owner decode and round-robin search from ptr (idle) or owner+1 (busy)
    always_comb begin
        own = '0;
        for (int i = 0; i < N; i++)
            if (gnt_q[i]) own = PW'(i);
        nxt     = (own == PW'(N - 1)) ? '0 : own + PW'(1);
        own_req = |(req & gnt_q);
        cand    = req & ~gnt_q;
        others  = |cand;
        start   = (state_q == BUSY) ? nxt : ptr_q;
        win     = start;
        jj      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            jj = int'(start) + k;
            if (jj >= N) jj = jj - N;
            if (cand[jj]) win = PW'(jj);
        end
        hot = {{(N-1){1'b0}}, 1'b1} << win;
    end

    // next state: busy exactly when some requester remains to be served
    always_comb begin
        state_d = (|req) ? BUSY : IDLE;
    end

    // grant, burst counter, pointer and register write decisions
    always_comb begin
        wr    = (state_q == BUSY) && own_req;
        rot   = (state_q == BUSY) && (!own_req || (cnt_q == MAXC && others));
        upd_d = wr;
        q_d   = wr ? wdata[int'(own)*W +: W] : q_q;
        ptr_d = rot ? nxt : ptr_q;
        if (state_q == IDLE || rot) begin
            gnt_d = others ? hot : '0;
            cnt_d = others ? CW'(1) : '0;
        end else begin
            gnt_d = gnt_q;
            cnt_d = (cnt_q == MAXC) ? cnt_q : cnt_q + CW'(1);
        end
    end

    assign gnt  = gnt_q;
    assign q    = q_q;
    assign upd  = upd_q;
    assign busy = (state_q == BUSY);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: randomized and directed checks against a behavioural arbiter model
module tb_reg_write_arbiter;
    localparam int N = 4, W = 8, MAXB = 4;

    logic           clk = 1'b0;
    logic           clr;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           upd, busy;

    int checks = 0, failures = 0;
    int m_own, m_ptr, m_cnt;
    logic [W-1:0] m_q;
    logic m_upd;
    logic [W-1:0] q_prev;

    reg_write_arbiter #(.N(N), .W(W), .MAXB(MAXB)) dut (
        .clk(clk), .clr(clr), .req(req), .wdata(wdata),
        .gnt(gnt), .q(q), .upd(upd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr(input int s, input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1; m_ptr = 0; m_cnt = 0; m_q = '0; m_upd = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0] oth;
        m_upd = 1'b0;
        if (m_own < 0) begin
            if (req != 0) begin m_own = rr(m_ptr, req); m_cnt = 1; end
        end else if (!req[m_own]) begin
            m_ptr = (m_own + 1) % N;
            m_own = rr(m_ptr, req);
            m_cnt = (m_own >= 0) ? 1 : 0;
        end else begin
            m_q   = wdata[m_own*W +: W];
            m_upd = 1'b1;
            oth   = req & ~(N'(1) << m_own);
            if (m_cnt < MAXB) m_cnt++;
            else if (oth != 0) begin
                m_ptr = (m_own + 1) % N;
                m_own = rr(m_ptr, oth);
                m_cnt = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), (m_own < 0) ? 32'd0 : 32'(1) << m_own);
        chk({tag, "_busy"}, 32'(busy), (m_own < 0) ? 32'd0 : 32'd1);
        chk({tag, "_q"}, 32'(q), 32'(m_q));
        chk({tag, "_upd"}, 32'(upd), 32'(m_upd));
    endtask

    task automatic cyc(input string tag, input logic [N-1:0] r, input logic [N*W-1:0] d);
        req = r; wdata = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        clr = 1'b1; req = '0;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        check_all("rst");
    endtask

    initial begin
        logic [N-1:0] rq;
        clr = 1'b1; req = '0; wdata = '0;
        model_reset();
        #12;
        @(negedge clk);
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_q", 32'(q), 0);
        do_reset();

        for (int i = 0; i < 3; i++) cyc("single", 4'b0001, 32'h0000_005A);
        chk("single_q", 32'(q), 32'h5A);
        cyc("single_drop", 4'b0000, '0);
        chk("single_idle", 32'(busy), 0);

        do_reset();
        for (int i = 0; i < 5; i++) cyc("fair", 4'b1111, 32'h1312_1110);
        chk("fair_rot", 32'(gnt), 32'b0010);
        for (int i = 0; i < 16; i++) cyc("fair", 4'b1111, 32'h1312_1110);

        do_reset();
        for (int i = 0; i < 3; i++) cyc("early", 4'b0011, 32'h0000_B1A0);
        q_prev = q;
        cyc("early_rel", 4'b0010, 32'h0000_B1C0);
        chk("early_gnt", 32'(gnt), 32'b0010);
        chk("early_noq", 32'(q), 32'(q_prev));
        cyc("early_w1", 4'b0010, 32'h0000_B1C0);
        chk("early_q1", 32'(q), 32'hB1);

        do_reset();
        for (int i = 0; i < 11; i++) cyc("sole", 4'b0100, {8'h0, 8'(i + 8'h40), 16'h0});
        chk("sole_gnt", 32'(gnt), 32'b0100);

        do_reset();
        cyc("wrap_pre", 4'b0100, 32'h0033_0000);
        cyc("wrap_pre", 4'b0000, '0);
        cyc("wrap", 4'b1001, 32'h7700_0066);
        chk("wrap_first", 32'(gnt), 32'b1000);
        for (int i = 0; i < 5; i++) cyc("wrap", 4'b1001, 32'h7700_0066);
        chk("wrap_second", 32'(gnt), 32'b0001);

        do_reset();
        for (int i = 0; i < 3; i++) cyc("async", 4'b1111, 32'hDDCC_BBAA);
        #2 clr = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 0);
        chk("async_q", 32'(q), 0);
        chk("async_upd", 32'(upd), 0);
        chk("async_busy", 32'(busy), 0);
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        cyc("async_after", 4'b1111, 32'hDDCC_BBAA);
        chk("async_first", 32'(gnt), 32'b0001);

        do_reset();
        rq = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            cyc("rand", rq, $urandom);
            chk("rand_onehot", 32'($onehot0(gnt)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
